// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/gnt/rvalid
// and the valid/ready handoff to the ID stage.
interface if_fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req_o;
    logic [PC_WIDTH-1:0]   imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [INST_WIDTH-1:0] imem_rdata_i;
    logic                  if_valid_o;
    logic [PC_WIDTH-1:0]   if_pc_o;
    logic [INST_WIDTH-1:0] if_inst_o;
    logic                  id_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        output if_valid_o, if_pc_o, if_inst_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        input  if_valid_o, if_pc_o, if_inst_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output id_ready_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC owner, single-outstanding
// imem requester, 2-entry instruction FIFO toward ID.
module if_fetch_unit #(
    parameter int                 PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                 INST_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] flush_pc_i,
    if_fetch_unit_if.master     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_n;
    logic [PC_WIDTH-1:0]   addr_q;
    logic [1:0]            count;
    logic [1:0]            count_n;
    logic                  head;
    logic                  tail;
    logic                  push;
    logic                  pop;
    logic                  if_valid;
    logic                  grant;
    logic [PC_WIDTH-1:0]   fifo_pc   [2];
    logic [INST_WIDTH-1:0] fifo_inst [2];

    assign if_valid = (count != 2'd0) & ~flush_i;
    assign pop      = if_valid & bus.id_ready_i;
    assign push     = (state == RSP) & bus.imem_rvalid_i & ~flush_i;
    assign grant    = (state == REQ) & bus.imem_gnt_i;
    assign count_n  = count + {1'b0, push} - {1'b0, pop};

    assign bus.imem_req_o  = (state == REQ);
    assign bus.imem_addr_o = pc;
    assign bus.if_valid_o  = if_valid;
    assign bus.if_pc_o     = fifo_pc[head];
    assign bus.if_inst_o   = fifo_inst[head];

    // Next fetch state and PC; a flush overrides every other move.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (flush_i) begin
            pc_n = {flush_pc_i[PC_WIDTH-1:2], 2'b00};
            unique case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = bus.imem_gnt_i ? DROP : REQ;
                RSP:     state_n = bus.imem_rvalid_i ? REQ : DROP;
                DROP:    state_n = bus.imem_rvalid_i ? REQ : DROP;
                default: state_n = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (count_n <= 2'd1) state_n = REQ;
                end
                REQ: begin
                    if (bus.imem_gnt_i) begin
                        state_n = RSP;
                        pc_n    = pc + PC_WIDTH'(4);
                    end
                end
                RSP: begin
                    if (bus.imem_rvalid_i)
                        state_n = (count_n <= 2'd1) ? REQ : IDLE;
                end
                DROP: begin
                    if (bus.imem_rvalid_i) state_n = REQ;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Control registers: FSM, PC, granted-address tag, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= '0;
            count  <= 2'd0;
            head   <= 1'b0;
            tail   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (grant & ~flush_i) addr_q <= pc;
            if (flush_i) begin
                count <= 2'd0;
                head  <= 1'b0;
                tail  <= 1'b0;
            end else begin
                count <= count_n;
                if (pop)  head <= ~head;
                if (push) tail <= ~tail;
            end
        end
    end

    // FIFO storage; zeroed at reset so outputs read 0 until first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[tail]   <= addr_q;
            fifo_inst[tail] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level model checked
// every cycle, plus directed scenarios with literal checks.
module tb_if_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_on;

    int errors = 0;
    int checks = 0;

    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_fetch_unit #(
        .PC_WIDTH(32), .RESET_PC(32'h0), .INST_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: FIFO as a queue of {pc,inst}, plus request/outstanding flags.
    logic [63:0] mq[$];
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_tag  = 32'h0;
    bit          m_req  = 0;
    bit          m_out  = 0;
    bit          m_drop = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_pc = 32'h0; m_req = 0; m_out = 0; m_drop = 0;
        end else if (flush) begin
            mq.delete();
            if (m_req) begin
                if (bus.imem_gnt_i) begin
                    m_req = 0; m_out = 1; m_drop = 1;
                end
            end else if (m_out) begin
                if (bus.imem_rvalid_i) begin
                    m_out = 0; m_req = 1;
                end else m_drop = 1;
            end else m_req = 1;
            m_pc = {flush_pc[31:2], 2'b00};
        end else begin
            if (mq.size() > 0 && bus.id_ready_i) void'(mq.pop_front());
            if (m_req) begin
                if (bus.imem_gnt_i) begin
                    m_tag = m_pc; m_pc = m_pc + 32'd4;
                    m_req = 0; m_out = 1; m_drop = 0;
                end
            end else if (m_out) begin
                if (bus.imem_rvalid_i) begin
                    if (!m_drop) mq.push_back({m_tag, bus.imem_rdata_i});
                    m_req  = m_drop || (mq.size() <= 1);
                    m_out  = 0;
                    m_drop = 0;
                end
            end else m_req = (mq.size() <= 1);
        end
    end

    // Per-cycle compare against the model; also logs grants and pops.
    logic [31:0] grants[$];
    logic [63:0] pops[$];

    initial forever begin
        @(negedge clk);
        chk("req", 64'(bus.imem_req_o), 64'(m_req));
        chk("addr", 64'(bus.imem_addr_o), 64'(m_pc));
        chk("valid", 64'(bus.if_valid_o),
            64'(mq.size() != 0 && !flush));
        if (bus.if_valid_o && mq.size() != 0)
            chk("head", {bus.if_pc_o, bus.if_inst_o}, mq[0]);
        if (bus.imem_req_o && bus.imem_gnt_i)
            grants.push_back(bus.imem_addr_o);
        if (bus.if_valid_o && bus.id_ready_i)
            pops.push_back({bus.if_pc_o, bus.if_inst_o});
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Zero-wait memory: grant whenever requested, data next cycle.
    logic        g_s;
    logic [31:0] a_s;
    initial forever begin
        @(negedge clk);
        g_s = bus.imem_req_o & bus.imem_gnt_i;
        a_s = bus.imem_addr_o;
        @(posedge clk);
        #2;
        if (mem_on) begin
            bus.imem_gnt_i    = bus.imem_req_o;
            bus.imem_rvalid_i = g_s;
            bus.imem_rdata_i  = g_s ? mem_word(a_s) : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0;
        bus.imem_rdata_i = 32'h0; flush = 0; flush_pc = 32'h0;
    endtask

    task automatic cyc(input logic g, input logic rv,
                       input logic [31:0] rd,
                       input logic f = 1'b0,
                       input logic [31:0] fp = 32'h0);
        bus.imem_gnt_i = g; bus.imem_rvalid_i = rv;
        bus.imem_rdata_i = rd; flush = f; flush_pc = fp;
        tick();
        clr();
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr();
        repeat (2) tick();
        grants.delete();
        pops.delete();
        rst_n = 1;
    endtask

    task automatic chk_out(input string nm, input logic r,
                           input logic [31:0] a, input logic v);
        chk({nm, "_req"}, 64'(bus.imem_req_o), 64'(r));
        chk({nm, "_addr"}, 64'(bus.imem_addr_o), 64'(a));
        chk({nm, "_valid"}, 64'(bus.if_valid_o), 64'(v));
    endtask

    task automatic chk_head(input string nm, input logic [31:0] p,
                            input logic [31:0] i);
        chk({nm, "_v"}, 64'(bus.if_valid_o), 64'd1);
        chk({nm, "_pc"}, 64'(bus.if_pc_o), 64'(p));
        chk({nm, "_inst"}, 64'(bus.if_inst_o), 64'(i));
    endtask

    initial begin
        int beef;
        rst_n = 0; mem_on = 0; bus.id_ready_i = 0;
        clr();
        #13;
        chk_out("rst", 0, 32'h0, 0);
        chk("rst_pc", 64'(bus.if_pc_o), 64'd0);
        chk("rst_inst", 64'(bus.if_inst_o), 64'd0);

        // Streaming fetch with ID always ready.
        mem_on = 1; bus.id_ready_i = 1;
        do_reset();
        repeat (8) tick();
        chk("t1_ngnt", 64'(grants.size() >= 3), 64'd1);
        chk("t1_npop", 64'(pops.size() >= 2), 64'd1);
        if (grants.size() >= 3) begin
            chk("t1_g0", 64'(grants[0]), 64'h0);
            chk("t1_g1", 64'(grants[1]), 64'h4);
            chk("t1_g2", 64'(grants[2]), 64'h8);
        end
        if (pops.size() >= 2) begin
            chk("t1_p0", pops[0], 64'h0000_0000_0000_0013);
            chk("t1_p1", pops[1], 64'h0000_0004_0010_0093);
        end

        // ID stalled: FIFO fills to two and fetch idles at 0x8.
        bus.id_ready_i = 0;
        do_reset();
        repeat (8) tick();
        chk_out("t2_full", 0, 32'h8, 1);
        chk_head("t2_head", 32'h0, 32'h0000_0013);
        chk("t2_ngnt", 64'(grants.size()), 64'd2);
        bus.id_ready_i = 1;
        repeat (6) tick();
        chk("t2_npop", 64'(pops.size() >= 2), 64'd1);
        if (pops.size() >= 2) begin
            chk("t2_p0", pops[0], 64'h0000_0000_0000_0013);
            chk("t2_p1", pops[1], 64'h0000_0004_0010_0093);
        end
        chk("t2_ng", 64'(grants.size() >= 3), 64'd1);
        if (grants.size() >= 3)
            chk("t2_g2", 64'(grants[2]), 64'h8);

        // Flush one cycle before rvalid: response dropped.
        mem_on = 0;
        do_reset();
        cyc(0, 0, 32'h0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'h0000_0013);
        cyc(1, 0, 32'h0);
        cyc(0, 0, 32'h0, 1, 32'h100);
        chk_out("t3_drop", 0, 32'h100, 0);
        cyc(0, 1, 32'hDEAD_BEEF);
        chk_out("t3_req", 1, 32'h100, 0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'h1111_1111);
        chk_head("t3_head", 32'h100, 32'h1111_1111);
        beef = 0;
        foreach (pops[i])
            if (pops[i][31:0] == 32'hDEAD_BEEF) beef++;
        chk("t3_nobeef", 64'(beef), 64'd0);

        // Flush coincident with rvalid: no push.
        do_reset();
        cyc(0, 0, 32'h0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'hBAD0_0001, 1, 32'h100);
        chk_out("t4a", 1, 32'h100, 0);

        // Flush coincident with grant: next rvalid discarded.
        do_reset();
        cyc(0, 0, 32'h0);
        cyc(1, 0, 32'h0, 1, 32'h100);
        chk_out("t4b_drop", 0, 32'h100, 0);
        cyc(0, 0, 32'h0);
        chk_out("t4b_wait", 0, 32'h100, 0);
        cyc(0, 1, 32'hBAD0_0002);
        chk_out("t4b_req", 1, 32'h100, 0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'h0000_0022);
        chk_head("t4b_head", 32'h100, 32'h0000_0022);

        // Unaligned redirect target and PC wrap.
        do_reset();
        cyc(0, 0, 32'h0);
        cyc(0, 0, 32'h0, 1, 32'hFFFF_FFFF);
        chk_out("t5_al", 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 32'h0);
        chk_out("t5_wrap", 0, 32'h0, 0);
        cyc(0, 1, 32'h0000_0033);
        chk_head("t5_head", 32'hFFFF_FFFC, 32'h0000_0033);

        // Reset while in RSP, then stray rvalids.
        bus.id_ready_i = 0;
        do_reset();
        cyc(0, 0, 32'h0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'h0000_0044);
        cyc(1, 0, 32'h0);
        chk_head("t6_pre", 32'h0, 32'h0000_0044);
        #1 rst_n = 0;
        #1;
        chk_out("t6_rst", 0, 32'h0, 0);
        chk("t6_pc", 64'(bus.if_pc_o), 64'd0);
        chk("t6_inst", 64'(bus.if_inst_o), 64'd0);
        tick();
        rst_n = 1;
        cyc(0, 1, 32'h0000_0055);
        cyc(0, 1, 32'h0000_0066);
        chk_out("t6_stray", 1, 32'h0, 0);
        cyc(1, 0, 32'h0);
        cyc(0, 1, 32'h0000_0077);
        chk_head("t6_head", 32'h0, 32'h0000_0077);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
